// File: rtl/md_defs.sv
// Shared encodings and defaults for the multiply/divide sequencer.
// Also holds small two's-complement helpers used by the arithmetic core.
package md_defs;

  localparam logic [1:0] MDOP_MULT  = 2'b00;
  localparam logic [1:0] MDOP_MULTU = 2'b01;
  localparam logic [1:0] MDOP_DIV   = 2'b10;
  localparam logic [1:0] MDOP_DIVU  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  localparam int DEF_CNT_W      = 4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } md_result_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed word; 0x80000000 maps to itself, which is correct read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational 32x32 multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
// Signed divide is done on magnitudes so the INT_MIN / -1 case wraps to 0x80000000 cleanly.
module muldiv_core
  import md_defs::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output md_result_t  res_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        dbz;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] div_rt;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    prod_s     = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    prod_u     = {32'd0, rs_i} * {32'd0, rt_i};
    signed_div = (op_i == MDOP_DIV);
    dbz        = op_i[1] & (rt_i == 32'd0);
    mag_rs     = signed_div ? abs32(rs_i) : rs_i;
    mag_rt     = signed_div ? abs32(rt_i) : rt_i;
    div_rt     = dbz ? 32'd1 : mag_rt;
    quo        = mag_rs / div_rt;
    rem        = mag_rs % div_rt;

    res_o.dbz = dbz;
    res_o.hi  = 32'd0;
    res_o.lo  = 32'd0;
    case (op_i)
      MDOP_MULT:  {res_o.hi, res_o.lo} = prod_s;
      MDOP_MULTU: {res_o.hi, res_o.lo} = prod_u;
      MDOP_DIV: begin
        res_o.lo = (rs_i[31] ^ rt_i[31]) ? neg32(quo) : quo;
        res_o.hi = rs_i[31] ? neg32(rem) : rem;
      end
      default: begin
        res_o.lo = quo;
        res_o.hi = rem;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_sched.sv
// Multi-cycle mult/div sequencer: holds HI/LO, counts off a fixed latency, and stalls D-stage
// HI/LO users until the result commits. The result is computed at start and parked in pend_*.
//
//   state   | meaning
//   IDLE    | no op in flight; mthi/mtlo and new starts accepted
//   BUSY    | op in flight; count_q cycles remain before commit
module muldiv_sched
  import md_defs::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [1:0]  E_mdop,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_mthi,
  input  logic        E_mtlo,
  input  logic        D_md_use,
  input  logic        cancel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);

  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [31:0]      pend_hi_q,  pend_hi_d;
  logic [31:0]      pend_lo_q,  pend_lo_d;
  logic             pend_dbz_q, pend_dbz_d;
  logic [31:0]      hi_q,       hi_d;
  logic [31:0]      lo_q,       lo_d;

  md_result_t core_res;

  muldiv_core u_core (
    .op_i  (E_mdop),
    .rs_i  (E_rs_val),
    .rt_i  (E_rt_val),
    .res_o (core_res)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (E_start && !cancel) begin
          pend_hi_d  = core_res.hi;
          pend_lo_d  = core_res.lo;
          pend_dbz_d = core_res.dbz;
          count_d    = E_mdop[1] ? CNT_DIV : CNT_MUL;
          state_d    = ST_BUSY;
        end else begin
          if (E_mthi) hi_d = E_rs_val;
          if (E_mtlo) lo_d = E_rs_val;
        end
      end
      default: begin
        // A flush on the final cycle still wins: the op never architecturally happened.
        if (cancel) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (count_q == CNT_ONE) begin
          if (!pend_dbz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      pend_dbz_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign md_stall = D_md_use & (busy | E_start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
